mem_port_arbiter: RTL and testbench

// - Shares the single-ported DPI-C memory model (ioMem_* port) between the instruction-fetch unit (IFU) and the load/store unit (LSU).
// - Grants one transaction at a time, with round-robin fairness.
// - Drives the memory's read/write strobes and routes the registered read data back to the owning requester.
// - A watchdog converts a missing mem_rvalid into an error response.

---
 rtl/mem_port_arbiter_if.sv | 49 ++++
 rtl/mem_port_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - IFU/LSU request-response and memory port bundle for mem_port_arbiter
// The arbiter uses the slave view; the requesters and memory model use the master view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic              ifu_req_valid;
  logic              ifu_req_ready;
  logic [ADDR_W-1:0] ifu_addr;
  logic              ifu_resp_valid;
  logic [DATA_W-1:0] ifu_resp_data;
  logic              ifu_resp_err;

  logic              lsu_req_valid;
  logic              lsu_req_ready;
  logic [ADDR_W-1:0] lsu_addr;
  logic              lsu_wen;
  logic [DATA_W-1:0] lsu_wdata;
  logic [7:0]        lsu_wmask;
  logic              lsu_resp_valid;
  logic [DATA_W-1:0] lsu_resp_data;
  logic              lsu_resp_err;

  logic              mem_ren;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [7:0]        mem_wmask;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rvalid;

  modport slave (
    input  ifu_req_valid, ifu_addr,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    input  mem_rdata, mem_rvalid,
    output ifu_req_ready, ifu_resp_valid, ifu_resp_data, ifu_resp_err,
    output lsu_req_ready, lsu_resp_valid, lsu_resp_data, lsu_resp_err,
    output mem_ren, mem_wen, mem_addr, mem_wdata, mem_wmask
  );

  modport master (
    output ifu_req_valid, ifu_addr,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    output mem_rdata, mem_rvalid,
    input  ifu_req_ready, ifu_resp_valid, ifu_resp_data, ifu_resp_err,
    input  lsu_req_ready, lsu_resp_valid, lsu_resp_data, lsu_resp_err,
    input  mem_ren, mem_wen, mem_addr, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin IFU/LSU arbiter for a single-ported memory with read watchdog
// One transaction in flight at a time; grants are combinational in IDLE, responses come from the WAIT states.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 15
) (
  input  logic               clock,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus
);
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_IF = 2'd1,
    WAIT_LS = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            prio_lsu_q, prio_lsu_d;
  logic            is_wr_q, is_wr_d;
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;

  logic              grant_lsu;
  logic              grant_ifu;
  logic              resp_valid;
  logic              resp_err;
  logic [DATA_W-1:0] resp_data;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      prio_lsu_q <= 1'b1;
      is_wr_q    <= 1'b0;
      wd_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      prio_lsu_q <= prio_lsu_d;
      is_wr_q    <= is_wr_d;
      wd_cnt_q   <= wd_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    prio_lsu_d = prio_lsu_q;
    is_wr_d    = is_wr_q;
    wd_cnt_d   = wd_cnt_q;
    grant_lsu  = 1'b0;
    grant_ifu  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_data  = '0;

    bus.ifu_req_ready  = 1'b0;
    bus.ifu_resp_valid = 1'b0;
    bus.ifu_resp_data  = '0;
    bus.ifu_resp_err   = 1'b0;
    bus.lsu_req_ready  = 1'b0;
    bus.lsu_resp_valid = 1'b0;
    bus.lsu_resp_data  = '0;
    bus.lsu_resp_err   = 1'b0;
    bus.mem_ren        = 1'b0;
    bus.mem_wen        = 1'b0;
    bus.mem_addr       = '0;
    bus.mem_wdata      = '0;
    bus.mem_wmask      = '0;

    // Outputs are held at zero while reset is asserted, even if the FSM is mid-transaction.
    if (!reset) begin
      case (state_q)
        IDLE: begin
          wd_cnt_d  = '0;
          grant_lsu = bus.lsu_req_valid && (!bus.ifu_req_valid || prio_lsu_q);
          grant_ifu = bus.ifu_req_valid && !grant_lsu;
          if (grant_lsu) begin
            bus.lsu_req_ready = 1'b1;
            bus.mem_addr      = bus.lsu_addr;
            if (bus.lsu_wen) begin
              bus.mem_wen   = 1'b1;
              bus.mem_wdata = bus.lsu_wdata;
              bus.mem_wmask = bus.lsu_wmask;
            end else begin
              bus.mem_ren = 1'b1;
            end
            is_wr_d    = bus.lsu_wen;
            prio_lsu_d = 1'b0;
            state_d    = WAIT_LS;
          end else if (grant_ifu) begin
            bus.ifu_req_ready = 1'b1;
            bus.mem_addr      = bus.ifu_addr;
            bus.mem_ren       = 1'b1;
            is_wr_d           = 1'b0;
            prio_lsu_d        = 1'b1;
            state_d           = WAIT_IF;
          end
        end
        WAIT_IF, WAIT_LS: begin
          if (state_q == WAIT_LS && is_wr_q) begin
            resp_valid = 1'b1;
            state_d    = IDLE;
            wd_cnt_d   = '0;
          end else if (bus.mem_rvalid) begin
            resp_valid = 1'b1;
            resp_data  = bus.mem_rdata;
            state_d    = IDLE;
            wd_cnt_d   = '0;
          end else if (wd_cnt_q == WD_LIMIT) begin
            resp_valid = 1'b1;
            resp_err   = 1'b1;
            state_d    = IDLE;
            wd_cnt_d   = '0;
          end else begin
            wd_cnt_d = wd_cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase

      if (state_q == WAIT_IF) begin
        bus.ifu_resp_valid = resp_valid;
        bus.ifu_resp_data  = resp_data;
        bus.ifu_resp_err   = resp_err;
      end
      if (state_q == WAIT_LS) begin
        bus.lsu_resp_valid = resp_valid;
        bus.lsu_resp_data  = resp_data;
        bus.lsu_resp_err   = resp_err;
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
// Stimulus pushes expected responses; a negedge monitor pops and compares each response pulse.
module tb_mem_port_arbiter;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 64;
  localparam int TIMEOUT = 15;

  logic clock;
  logic reset;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  typedef struct {
    logic        lsu;
    logic [63:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          passed = 0;
  int          total  = 0;
  int          cyc    = 0;
  logic        suppress   = 1'b0;
  logic        stray      = 1'b0;
  logic        fixed_en   = 1'b0;
  logic [63:0] fixed_data = 64'd0;
  logic        exp_order [4];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [63:0] exp_rd(input logic [31:0] a);
    return {~a, a};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Memory model: registered read data one cycle after mem_ren.
  always @(posedge clock) begin
    cyc            <= cyc + 1;
    bus.mem_rvalid <= (bus.mem_ren && !suppress) || stray;
    bus.mem_rdata  <= fixed_en ? fixed_data : exp_rd(bus.mem_addr);
  end

  always @(negedge clock) begin
    if (bus.ifu_resp_valid || bus.lsu_resp_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_resp", {62'd0, bus.lsu_resp_valid, bus.ifu_resp_valid}, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("resp_lsu_valid", bus.lsu_resp_valid, e.lsu);
        check("resp_ifu_valid", bus.ifu_resp_valid, !e.lsu);
        check("resp_data", e.lsu ? bus.lsu_resp_data : bus.ifu_resp_data, e.data);
        check("resp_err", e.lsu ? bus.lsu_resp_err : bus.ifu_resp_err, e.err);
        check("resp_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic drive_edge();
    @(posedge clock);
    #2;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic clear_inputs();
    bus.ifu_req_valid = 1'b0;
    bus.ifu_addr      = '0;
    bus.lsu_req_valid = 1'b0;
    bus.lsu_addr      = '0;
    bus.lsu_wen       = 1'b0;
    bus.lsu_wdata     = '0;
    bus.lsu_wmask     = '0;
  endtask

  task automatic do_reset();
    drive_edge();
    reset = 1'b1;
    drive_edge();
    reset = 1'b0;
  endtask

  initial begin
    int grants;
    int stall_ready;
    exp_order[0] = 1'b1;
    exp_order[1] = 1'b0;
    exp_order[2] = 1'b1;
    exp_order[3] = 1'b0;

    // Reset with requests pending: everything must stay quiet.
    reset = 1'b1;
    clear_inputs();
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h1234;
    bus.lsu_req_valid = 1'b1;
    bus.lsu_wen       = 1'b1;
    bus.lsu_wdata     = 64'hFFFF;
    bus.lsu_wmask     = 8'hFF;
    repeat (3) @(posedge clock);
    sample();
    check("rst_ifu_ready", bus.ifu_req_ready, 1'b0);
    check("rst_lsu_ready", bus.lsu_req_ready, 1'b0);
    check("rst_mem_ren", bus.mem_ren, 1'b0);
    check("rst_mem_wen", bus.mem_wen, 1'b0);
    check("rst_mem_addr", bus.mem_addr, 64'd0);
    check("rst_mem_wdata", bus.mem_wdata, 64'd0);
    drive_edge();
    clear_inputs();
    reset = 1'b0;
    sample();
    check("post_rst_resp", {bus.ifu_resp_valid, bus.lsu_resp_valid}, 64'd0);
    check("post_rst_ren", bus.mem_ren, 1'b0);

    // IFU read.
    fixed_en   = 1'b1;
    fixed_data = 64'h1122334455667788;
    drive_edge();
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h8000_0000;
    sample();
    check("t1_ifu_ready", bus.ifu_req_ready, 1'b1);
    check("t1_lsu_ready", bus.lsu_req_ready, 1'b0);
    check("t1_mem_ren", bus.mem_ren, 1'b1);
    check("t1_mem_wen", bus.mem_wen, 1'b0);
    check("t1_mem_addr", bus.mem_addr, 64'h8000_0000);
    sb.push_back('{lsu: 1'b0, data: 64'h1122334455667788, err: 1'b0, cyc: cyc + 1});
    drive_edge();
    bus.ifu_req_valid = 1'b0;
    sample();
    check("t1_ren_single", bus.mem_ren, 1'b0);
    check("t1_ready_wait", bus.ifu_req_ready, 1'b0);
    drive_edge();
    fixed_en = 1'b0;
    sample();

    // LSU write.
    drive_edge();
    bus.lsu_req_valid = 1'b1;
    bus.lsu_wen       = 1'b1;
    bus.lsu_addr      = 32'h8000_0010;
    bus.lsu_wdata     = 64'hDEADBEEF;
    bus.lsu_wmask     = 8'h0F;
    sample();
    check("t2_lsu_ready", bus.lsu_req_ready, 1'b1);
    check("t2_mem_wen", bus.mem_wen, 1'b1);
    check("t2_mem_ren", bus.mem_ren, 1'b0);
    check("t2_mem_addr", bus.mem_addr, 64'h8000_0010);
    check("t2_mem_wdata", bus.mem_wdata, 64'hDEADBEEF);
    check("t2_mem_wmask", bus.mem_wmask, 64'h0F);
    sb.push_back('{lsu: 1'b1, data: 64'd0, err: 1'b0, cyc: cyc + 1});
    drive_edge();
    clear_inputs();
    sample();
    check("t2_wen_single", bus.mem_wen, 1'b0);
    check("t2_wdata_idle", bus.mem_wdata, 64'd0);
    drive_edge();
    sample();

    // Both requesting continuously after reset: LSU, IFU, LSU, IFU.
    do_reset();
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h8000_1000;
    bus.lsu_req_valid = 1'b1;
    bus.lsu_wen       = 1'b0;
    bus.lsu_addr      = 32'h8000_2000;
    grants = 0;
    for (int i = 0; i < 8; i++) begin
      sample();
      if (bus.lsu_req_ready || bus.ifu_req_ready) begin
        if (grants < 4) check("t3_order_lsu", bus.lsu_req_ready, exp_order[grants]);
        check("t3_one_ready", bus.lsu_req_ready & bus.ifu_req_ready, 1'b0);
        sb.push_back('{lsu: bus.lsu_req_ready,
                       data: exp_rd(bus.lsu_req_ready ? bus.lsu_addr : bus.ifu_addr),
                       err: 1'b0, cyc: cyc + 1});
        grants++;
      end
      if (i != 7) drive_edge();
    end
    check("t3_grant_count", grants, 4);
    drive_edge();
    clear_inputs();
    sample();

    // Watchdog: no rvalid, error after TIMEOUT idle WAIT cycles, then LSU is served.
    suppress = 1'b1;
    drive_edge();
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h8000_3000;
    sample();
    check("t4_ifu_ready", bus.ifu_req_ready, 1'b1);
    sb.push_back('{lsu: 1'b0, data: 64'd0, err: 1'b1, cyc: cyc + TIMEOUT + 1});
    drive_edge();
    bus.ifu_req_valid = 1'b0;
    bus.lsu_req_valid = 1'b1;
    bus.lsu_wen       = 1'b1;
    bus.lsu_addr      = 32'h8000_4000;
    bus.lsu_wdata     = 64'h55;
    bus.lsu_wmask     = 8'hFF;
    stall_ready = 0;
    for (int i = 0; i < TIMEOUT + 1; i++) begin
      sample();
      if (bus.lsu_req_ready) stall_ready++;
      drive_edge();
    end
    check("t4_no_grant_in_wait", stall_ready, 0);
    sample();
    check("t4_next_served", bus.lsu_req_ready, 1'b1);
    sb.push_back('{lsu: 1'b1, data: 64'd0, err: 1'b0, cyc: cyc + 1});
    drive_edge();
    clear_inputs();
    suppress = 1'b0;
    sample();

    // Reset while in WAIT_IF drops the transaction.
    drive_edge();
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h8000_5000;
    sample();
    check("t5_ifu_ready", bus.ifu_req_ready, 1'b1);
    drive_edge();
    bus.ifu_req_valid = 1'b0;
    reset = 1'b1;
    sample();
    check("t5_no_ifu_resp", bus.ifu_resp_valid, 1'b0);
    check("t5_ifu_data", bus.ifu_resp_data, 64'd0);
    check("t5_lsu_resp", bus.lsu_resp_valid, 1'b0);
    drive_edge();
    reset = 1'b0;
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h8000_6000;
    bus.lsu_req_valid = 1'b1;
    bus.lsu_wen       = 1'b0;
    bus.lsu_addr      = 32'h8000_7000;
    sample();
    check("t5_first_lsu", bus.lsu_req_ready, 1'b1);
    check("t5_first_not_ifu", bus.ifu_req_ready, 1'b0);
    sb.push_back('{lsu: 1'b1, data: exp_rd(32'h8000_7000), err: 1'b0, cyc: cyc + 1});
    drive_edge();
    clear_inputs();
    sample();

    // Stray rvalid in IDLE.
    drive_edge();
    stray = 1'b1;
    drive_edge();
    stray = 1'b0;
    sample();
    check("t6_no_ifu_resp", bus.ifu_resp_valid, 1'b0);
    check("t6_no_lsu_resp", bus.lsu_resp_valid, 1'b0);
    drive_edge();
    sample();
    drive_edge();
    sample();

    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
